charlieplex_pwm: RTL and testbench
==================================

// Module: charlieplex_pwm
// PURPOSE
//  Wishbone-slave charlieplexed LED driver with per-LED PWM brightness, generalised to NPINS pins
//  (NPINS*(NPINS-1) LEDs). Scans one anode pin per row, PWMs the cathodes, blanks between rows.
//  Its charlieplex_oe/charlieplex_o outputs feed the board's SB_IO tristate pins.
//  Double-buffered brightness RAM: host writes a back buffer and commits it at a frame boundary.
// PARAMETERS
//  NPINS        7    charlieplex pin count (>=2); NLEDS = NPINS*(NPINS-1)
//  PWM_BITS     8    brightness resolution; PWM period = 2**PWM_BITS ticks; PWM_BITS <= DATA_W
//  DATA_W       8    wishbone data width
//  ADDR_W       8    wishbone address width; must satisfy 2**ADDR_W > NLEDS
//  PRESCALE     4    clk_i cycles per PWM tick (>=1)
//  BLANK_TICKS  2    PWM ticks with all pins hi-Z between rows (anti-ghosting, >=1)
// PORTS
//  clk_i           in   1       system clock
//  rst_ni          in   1       asynchronous reset, active low
//  wb_cyc_i        in   1       wishbone cycle
//  wb_stb_i        in   1       wishbone strobe
//  wb_we_i         in   1       write enable
//  wb_adr_i        in   ADDR_W  address: 0..NLEDS-1 back-buffer LED, NLEDS = CTRL
//  wb_dat_i        in   DATA_W  write data
//  wb_dat_o        out  DATA_W  read data, valid with wb_ack_o
//  wb_ack_o        out  1       one-cycle acknowledge
//  charlieplex_oe  out  NPINS   per-pin output enable (0 = hi-Z)
//  charlieplex_o   out  NPINS   per-pin output level
// BEHAVIOUR
//  Reset (async, rst_ni=0): all outputs 0; both buffers 0; CTRL=0; row=0, tick=0, phase=BLANK.
//  Wishbone: request = cyc&stb&!ack; ack asserted exactly 1 cycle later, for 1 cycle; no stall.
//   LED addr write: back[adr] <= dat_i[PWM_BITS-1:0]; read returns back[adr] zero-extended.
//   CTRL: bit0 EN (r/w); bit1 COMMIT (write 1 sets pending; reads 1 while pending); other bits 0.
//   Address > NLEDS: write ignored, read 0, still acked.
//  LED index: anode a, cathode k!=a -> idx = a*(NPINS-1) + (k<a ? k : k-1).
//  Scan FSM, states BLANK -> ON -> BLANK; one tick = PRESCALE clk_i cycles:
//   BLANK: oe=0, o=0 for BLANK_TICKS ticks, then ON with pwm=0.
//   ON: pin a: oe=1,o=1; pin k: oe=1,o=0 iff pwm < duty(front[idx(a,k)]), else oe=0.
//       Lasts 2**PWM_BITS ticks; then row <= (row==NPINS-1) ? 0 : row+1, go to BLANK.
//   Outputs are registered: change 1 cycle after the tick boundary.
//  Brightness 0 -> never on; 2**PWM_BITS-1 -> on for all but one tick of the ON period.
//  Commit: when pending and the FSM enters BLANK of row 0 (frame start), front<=back in that cycle,
//   pending cleared. Commit write in the same cycle as the swap: write is taken, swap still happens,
//   pending stays set for the next frame. LED write same cycle as swap: front gets the old value.
//  EN=0: oe forced 0 (all hi-Z), scan keeps running, commits still processed.
//  Reset mid-frame: immediate hi-Z, scan restarts at row 0 BLANK.
// CONFIGURATION
//  CHARLIEPLEX_GAMMA_EN defined: duty(b) = (b*b) >> PWM_BITS (square-law gamma, 2*PWM_BITS product).
//  Not defined: duty(b) = b (linear). Register map and timing identical in both builds.
// STRUCTURE
//  charlieplex_pkg: CTRL bit positions (CTRL_EN=0, CTRL_COMMIT=1), scan state enum
//   {ST_BLANK, ST_ON}, function led_index(a,k,npins).
//  Sub-module charlieplex_scan: prescaler, tick/pwm counter, row counter, FSM; exports row, pwm,
//   phase, frame_start. Top holds wishbone, buffers, compare/gamma and output registers.
// TESTING
//  Reset: hold rst_ni=0 -> oe=0, o=0, ack=0; read CTRL after release -> 0x00.
//  NPINS=7, PWM_BITS=8, PRESCALE=1: write LED 0 = 8'h80, CTRL=3 -> after next frame start, row 0 ON:
//   pin0 oe=1,o=1; pin1 oe=1,o=0 for 128 cycles then oe=0 for 128; other pins hi-Z.
//  Commit gating: write LED 0=8'hFF without commit -> pin1 unchanged for a full frame; CTRL bit1=0.
//  Out-of-range: write adr 8'hC8 -> ack in 1 cycle; read adr 8'hC8 -> 0; LEDs unchanged.
//  Row wrap + blank: count 7 rows each 2 blank + 256 on cycles; all oe=0 during blanks; row 6 -> 0.
//  CHARLIEPLEX_GAMMA_EN: LED = 8'h80 -> duty 64 (on 64 cycles); 8'h10 -> duty 1; without macro 128 / 16.

Source files
------------

// File: rtl/charlieplex_pkg.sv
// Shared definitions for the charlieplexed PWM LED driver: CTRL bit map,
// scan phase encoding and the (anode, cathode) -> LED index mapping.
package charlieplex_pkg;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_COMMIT = 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    // Each anode row owns NPINS-1 consecutive LEDs; its own pin is skipped.
    function automatic int led_index(input int a, input int k, input int npins);
        return a * (npins - 1) + ((k < a) ? k : k - 1);
    endfunction

endpackage

// File: rtl/charlieplex_scan.sv
// Row/PWM timebase: prescaler, blank/PWM tick counters, row counter and the
// BLANK/ON scan FSM. frame_start_o pulses in the cycle row 0 BLANK is entered.
module charlieplex_scan
    import charlieplex_pkg::*;
#(
    parameter int NPINS       = 7,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 4,
    parameter int BLANK_TICKS = 2,
    parameter int ROW_W       = $clog2(NPINS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic [ROW_W-1:0]    row_o,
    output logic [PWM_BITS-1:0] pwm_o,
    output scan_state_e         phase_o,
    output logic                frame_start_o
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

    scan_state_e         state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [BLK_W-1:0]    blank_q, blank_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick;
    logic                frame_start;

    assign tick = (pre_q == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_BLANK;
            row_q   <= '0;
            pwm_q   <= '0;
            blank_q <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pwm_q   <= pwm_d;
            blank_q <= blank_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        pwm_d       = pwm_q;
        blank_d     = blank_q;
        frame_start = 1'b0;
        pre_d       = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
            case (state_q)
                ST_BLANK: begin
                    if (blank_q == BLK_W'(BLANK_TICKS - 1)) begin
                        state_d = ST_ON;
                        pwm_d   = '0;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
                ST_ON: begin
                    if (&pwm_q) begin
                        state_d = ST_BLANK;
                        blank_d = '0;
                        if (row_q == ROW_W'(NPINS - 1)) begin
                            row_d       = '0;
                            frame_start = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        pwm_d = pwm_q + 1'b1;
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    assign row_o         = row_q;
    assign pwm_o         = pwm_q;
    assign phase_o       = state_q;
    assign frame_start_o = frame_start;

endmodule

// File: rtl/charlieplex_pwm.sv
// Wishbone charlieplex LED driver with double-buffered per-LED PWM brightness.
// Define CHARLIEPLEX_GAMMA_EN for square-law gamma on the duty cycle.
module charlieplex_pwm
    import charlieplex_pkg::*;
#(
    parameter int NPINS       = 7,
    parameter int PWM_BITS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int PRESCALE    = 4,
    parameter int BLANK_TICKS = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic [NPINS-1:0]  charlieplex_oe,
    output logic [NPINS-1:0]  charlieplex_o
);

    localparam int NLEDS = NPINS * (NPINS - 1);
    localparam int ROW_W = $clog2(NPINS);

    logic [PWM_BITS-1:0] back_q  [NLEDS];
    logic [PWM_BITS-1:0] front_q [NLEDS];
    logic                en_q, en_d;
    logic                pending_q, pending_d;
    logic                ack_q;
    logic [DATA_W-1:0]   dat_q, rd_d;
    logic [NPINS-1:0]    oe_q, oe_d;
    logic [NPINS-1:0]    o_q, o_d;

    logic                wb_req, sel_led, sel_ctrl, led_wr, ctrl_wr, swap;
    logic [ROW_W-1:0]    scan_row;
    logic [PWM_BITS-1:0] scan_pwm;
    scan_state_e         scan_phase;
    logic                frame_start;

    charlieplex_scan #(
        .NPINS       (NPINS),
        .PWM_BITS    (PWM_BITS),
        .PRESCALE    (PRESCALE),
        .BLANK_TICKS (BLANK_TICKS),
        .ROW_W       (ROW_W)
    ) u_scan (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .row_o         (scan_row),
        .pwm_o         (scan_pwm),
        .phase_o       (scan_phase),
        .frame_start_o (frame_start)
    );

    // Wishbone decode; the !ack term keeps a held strobe from re-triggering.
    assign wb_req   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign sel_led  = (wb_adr_i < ADDR_W'(NLEDS));
    assign sel_ctrl = (wb_adr_i == ADDR_W'(NLEDS));
    assign led_wr   = wb_req & wb_we_i & sel_led;
    assign ctrl_wr  = wb_req & wb_we_i & sel_ctrl;
    assign swap     = pending_q & frame_start;

    always_comb begin
        en_d      = ctrl_wr ? wb_dat_i[CTRL_EN] : en_q;
        pending_d = pending_q;
        // A fresh commit request wins over the swap that clears the old one.
        if (ctrl_wr && wb_dat_i[CTRL_COMMIT]) begin
            pending_d = 1'b1;
        end else if (swap) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        rd_d = '0;
        if (sel_led) begin
            for (int i = 0; i < NLEDS; i++) begin
                if (wb_adr_i == ADDR_W'(i)) begin
                    rd_d[PWM_BITS-1:0] = back_q[i];
                end
            end
        end else if (sel_ctrl) begin
            rd_d[CTRL_EN]     = en_q;
            rd_d[CTRL_COMMIT] = pending_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q      <= 1'b0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            oe_q      <= '0;
            o_q       <= '0;
            for (int i = 0; i < NLEDS; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
        end else begin
            en_q      <= en_d;
            pending_q <= pending_d;
            ack_q     <= wb_req;
            dat_q     <= (wb_req && !wb_we_i) ? rd_d : '0;
            oe_q      <= oe_d;
            o_q       <= o_d;
            for (int i = 0; i < NLEDS; i++) begin
                if (led_wr && (wb_adr_i == ADDR_W'(i))) begin
                    back_q[i] <= wb_dat_i[PWM_BITS-1:0];
                end
                // Same-cycle LED writes land in back only; front copies the old value.
                if (swap) begin
                    front_q[i] <= back_q[i];
                end
            end
        end
    end

    // Per pin: candidate brightness for every possible anode row, then row select.
    generate
        for (genvar gi = 0; gi < NPINS; gi++) begin : g_pin
            logic [PWM_BITS-1:0] cand [NPINS];
            logic [PWM_BITS-1:0] bright;
            logic [PWM_BITS-1:0] duty;
            logic                is_anode;
            logic                lit;

            for (genvar gj = 0; gj < NPINS; gj++) begin : g_row
                if (gi == gj) begin : g_self
                    assign cand[gj] = '0;
                end else begin : g_led
                    localparam int IDX = led_index(gj, gi, NPINS);
                    assign cand[gj] = front_q[IDX];
                end
            end

            always_comb begin
                bright = '0;
                for (int r = 0; r < NPINS; r++) begin
                    if (scan_row == ROW_W'(r)) begin
                        bright = cand[r];
                    end
                end
            end

`ifdef CHARLIEPLEX_GAMMA_EN
            logic [2*PWM_BITS-1:0] sq;
            assign sq   = {{PWM_BITS{1'b0}}, bright} * {{PWM_BITS{1'b0}}, bright};
            assign duty = sq[2*PWM_BITS-1:PWM_BITS];
`else
            assign duty = bright;
`endif

            assign is_anode = (scan_phase == ST_ON) && (scan_row == ROW_W'(gi));
            assign lit      = (scan_phase == ST_ON) && !is_anode && (scan_pwm < duty);
            assign oe_d[gi] = en_q & (is_anode | lit);
            assign o_d[gi]  = is_anode;
        end
    endgenerate

    assign wb_ack_o       = ack_q;
    assign wb_dat_o       = dat_q;
    assign charlieplex_oe = oe_q;
    assign charlieplex_o  = o_q;

endmodule

// File: tb/tb_charlieplex_pwm.sv
// Directed bench for charlieplex_pwm (NPINS=7, PWM_BITS=8, PRESCALE=1, BLANK_TICKS=2).
module tb_charlieplex_pwm;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       wb_cyc_i = 1'b0;
    logic       wb_stb_i = 1'b0;
    logic       wb_we_i = 1'b0;
    logic [7:0] wb_adr_i = '0;
    logic [7:0] wb_dat_i = '0;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic [6:0] charlieplex_oe;
    logic [6:0] charlieplex_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    charlieplex_pwm #(
        .NPINS(7), .PWM_BITS(8), .DATA_W(8), .ADDR_W(8), .PRESCALE(1), .BLANK_TICKS(2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wb_cyc_i       (wb_cyc_i),
        .wb_stb_i       (wb_stb_i),
        .wb_we_i        (wb_we_i),
        .wb_adr_i       (wb_adr_i),
        .wb_dat_i       (wb_dat_i),
        .wb_dat_o       (wb_dat_o),
        .wb_ack_o       (wb_ack_o),
        .charlieplex_oe (charlieplex_oe),
        .charlieplex_o  (charlieplex_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [7:0] dat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr;  wb_dat_i = dat;
        @(negedge clk_i);
        check("wr_ack", wb_ack_o, 1'b1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        $display("WB write adr=%02h dat=%02h ack=%0b", adr, dat, wb_ack_o);
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [7:0] dat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = adr;
        @(negedge clk_i);
        check("rd_ack", wb_ack_o, 1'b1);
        dat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        $display("WB read  adr=%02h dat=%02h ack=%0b", adr, dat, wb_ack_o);
    endtask

    // Returns at the negedge showing the first registered cycle of row 0 ON.
    task automatic wait_row0(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = charlieplex_oe[0];
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            if (charlieplex_oe[0] && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = charlieplex_oe[0];
        end
    endtask

    // Measure pin1 (LED 0) over a row-0 ON period plus the following blank.
    task automatic measure_led0(output int on_cnt, output int first_off, output int bad);
        on_cnt = 0; first_off = -1; bad = 0;
        for (int c = 0; c < 258; c++) begin
            if (c > 0) @(negedge clk_i);
            if (c < 256) begin
                if (charlieplex_oe[1]) on_cnt++;
                else if (first_off < 0) first_off = c;
                if (!charlieplex_oe[0] || charlieplex_o != 7'b0000001) bad++;
                if ((charlieplex_oe & 7'b1111100) != 7'b0) bad++;
            end else if (charlieplex_oe != 7'b0) begin
                bad++;
            end
        end
    endtask

    task automatic sync_and_measure(input string tag, output int on_cnt, output int first_off);
        bit ok1, ok2;
        int bad;
        wait_row0(ok1);
        wait_row0(ok2);
        check({tag, "_sync"}, {30'd0, ok1, ok2}, 32'd3);
        measure_led0(on_cnt, first_off, bad);
        check({tag, "_pins"}, bad, 0);
        $display("Row0 %s: led0 on=%0d first_off=%0d", tag, on_cnt, first_off);
    endtask

    initial begin
        logic [7:0] rd;
        int on_cnt, first_off, anode_cnt, blank_cnt, nz;
        bit ok;

        // Reset held
        repeat (3) @(negedge clk_i);
        check("rst_oe", charlieplex_oe, 7'h00);
        check("rst_o", charlieplex_o, 7'h00);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat", wb_dat_o, 8'h00);
        rst_ni = 1'b1;
        wb_read(8'd42, rd);
        check("ctrl_after_rst", rd, 8'h00);

        // Basic commit: LED0 = 0x80 -> 128 on, 128 off
        wb_write(8'd42, 8'h01);
        wb_write(8'd0, 8'h80);
        wb_read(8'd0, rd);
        check("led0_readback", rd, 8'h80);
        wb_write(8'd42, 8'h03);
        sync_and_measure("b80", on_cnt, first_off);
        check("b80_on", on_cnt, 128);
        check("b80_first_off", first_off, 128);
        wb_read(8'd42, rd);
        check("ctrl_committed", rd, 8'h01);

        // Commit gating: new back value without commit stays invisible
        wb_write(8'd0, 8'hFF);
        sync_and_measure("gated", on_cnt, first_off);
        check("gated_on", on_cnt, 128);
        wb_read(8'd42, rd);
        check("gated_ctrl", rd, 8'h01);
        wb_write(8'd42, 8'h03);
        sync_and_measure("bFF", on_cnt, first_off);
        check("bFF_on", on_cnt, 255);
        check("bFF_first_off", first_off, 255);

        // Out-of-range address
        wb_write(8'hC8, 8'h55);
        @(negedge clk_i);
        check("oor_ack_drop", wb_ack_o, 1'b0);
        wb_read(8'hC8, rd);
        check("oor_read", rd, 8'h00);
        wb_read(8'd0, rd);
        check("oor_led0", rd, 8'hFF);
        wb_read(8'd1, rd);
        check("oor_led1", rd, 8'h00);

        // Duty law
        wb_write(8'd0, 8'h80);
        wb_write(8'd42, 8'h03);
        sync_and_measure("duty80", on_cnt, first_off);
`ifdef CHARLIEPLEX_GAMMA_EN
        check("duty80_on", on_cnt, 64);
`else
        check("duty80_on", on_cnt, 128);
`endif
        wb_write(8'd0, 8'h10);
        wb_write(8'd42, 8'h03);
        sync_and_measure("duty10", on_cnt, first_off);
`ifdef CHARLIEPLEX_GAMMA_EN
        check("duty10_on", on_cnt, 1);
`else
        check("duty10_on", on_cnt, 16);
`endif

        // Row sequence, blanking and wrap
        wait_row0(ok);
        check("wrap_sync", ok, 1'b1);
        for (int r = 0; r < 7; r++) begin
            anode_cnt = 0; blank_cnt = 0;
            for (int c = 0; c < 258; c++) begin
                if (c > 0) @(negedge clk_i);
                if (c < 256) begin
                    if (charlieplex_oe[r] && charlieplex_o[r]) anode_cnt++;
                end else if (charlieplex_oe == 7'b0) begin
                    blank_cnt++;
                end
            end
            @(negedge clk_i);
            check($sformatf("row%0d_anode", r), anode_cnt, 256);
            check($sformatf("row%0d_blank", r), blank_cnt, 2);
            $display("Row %0d: anode=%0d blank=%0d", r, anode_cnt, blank_cnt);
        end
        check("wrap_row0", {charlieplex_oe[0], charlieplex_o[0]}, 2'b11);

        // EN=0: all hi-Z, commits still processed
        wb_write(8'd0, 8'h20);
        wb_write(8'd42, 8'h02);
        nz = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            if (charlieplex_oe != 7'b0) nz++;
        end
        check("en0_hiz", nz, 0);
        wb_read(8'd42, rd);
        check("en0_commit_done", rd, 8'h00);
        wb_write(8'd42, 8'h01);
        sync_and_measure("en0", on_cnt, first_off);
`ifdef CHARLIEPLEX_GAMMA_EN
        check("en0_on", on_cnt, 4);
`else
        check("en0_on", on_cnt, 32);
`endif

        // Reset mid-frame
        wait_row0(ok);
        check("mid_sync", ok, 1'b1);
        repeat (10) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_oe", charlieplex_oe, 7'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wb_read(8'd42, rd);
        check("mid_rst_ctrl", rd, 8'h00);
        wb_read(8'd0, rd);
        check("mid_rst_led0", rd, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
